// File: rtl/mips_control_unit_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_control_unit_pkg;

  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 6;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10,
    ALU_OP_RSVD  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the FSM's alu_op plus the R-type funct field to an ALU operation code.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module mips_alu_decoder
  import mips_control_unit_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  // Unknown funct codes fall back to add so a stray encoding never stalls the datapath
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// Moore FSM sequencing the multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Latency: 2..5 cycles per instruction, FETCH to last state inclusive.
// Backpressure: none; the FSM advances every cycle, rst aborts at once.
module mips_control_unit
  import mips_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t  state_q;
  state_t  state_d;
  alu_op_t alu_op;
  logic    pc_write;
  logic    branch;
  logic    iord_c;
  logic    mem_write_c;
  logic    ir_write_c;
  logic    reg_write_c;
  logic    done_c;
  logic    illegal_c;

  // State register; reset lands in FETCH immediately, even mid-instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and Moore outputs; opcode is only consulted in DECODE and MEMADR
  always_comb begin
    state_d     = S_FETCH;
    alu_op      = ALU_OP_ADD;
    pc_write    = 1'b0;
    branch      = 1'b0;
    iord_c      = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    illegal_c   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b01;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
            done_c    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord_c  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_MEMWR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        done_c    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        done_c   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Side-effecting strobes are masked while rst is held; the rest show FETCH values
  always_comb begin
    pc_en      = ~rst & (pc_write | (branch & zero));
    iord       = iord_c;
    mem_write  = ~rst & mem_write_c;
    ir_write   = ~rst & ir_write_c;
    reg_write  = ~rst & reg_write_c;
    instr_done = ~rst & done_c;
    illegal_op = ~rst & illegal_c;
  end

  mips_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed-vector bench for mips_control_unit.
// Latency: checks every cycle of each instruction sequence.
// Backpressure: n/a.
module tb_mips_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       instr_done, illegal_op;

  int total;
  int bad;

  // {pc_en,iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
  //  alu_src_b[1:0],pc_src[1:0],alu_control[2:0],instr_done,illegal_op}
  logic [16:0] obs;
  assign obs = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, pc_src, alu_control, instr_done, illegal_op};

  localparam logic [16:0] V_RST    = 17'b0_0_0_0_0_0_0_0_01_00_010_0_0;
  localparam logic [16:0] V_FETCH  = 17'b1_0_0_1_0_0_0_0_01_00_010_0_0;
  localparam logic [16:0] V_DECODE = 17'b0_0_0_0_0_0_0_0_11_00_010_0_0;
  localparam logic [16:0] V_DEC_IL = 17'b0_0_0_0_0_0_0_0_11_00_010_1_1;
  localparam logic [16:0] V_MEMADR = 17'b0_0_0_0_0_0_0_1_10_00_010_0_0;
  localparam logic [16:0] V_MEMRD  = 17'b0_1_0_0_0_0_0_0_00_00_010_0_0;
  localparam logic [16:0] V_MEMWB  = 17'b0_0_0_0_0_1_1_0_00_00_010_1_0;
  localparam logic [16:0] V_MEMWR  = 17'b0_1_1_0_0_0_0_0_00_00_010_1_0;
  localparam logic [16:0] V_EXEC_B = 17'b0_0_0_0_0_0_0_1_00_00_000_0_0;
  localparam logic [16:0] V_ALUWB  = 17'b0_0_0_0_1_0_1_0_00_00_010_1_0;
  localparam logic [16:0] V_ADDIWB = 17'b0_0_0_0_0_0_1_0_00_00_010_1_0;
  localparam logic [16:0] V_BR_Z1  = 17'b1_0_0_0_0_0_0_1_00_01_110_1_0;
  localparam logic [16:0] V_BR_Z0  = 17'b0_0_0_0_0_0_0_1_00_01_110_1_0;
  localparam logic [16:0] V_JUMP   = 17'b1_0_0_0_0_0_0_0_00_10_010_1_0;

  mips_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .pc_en       (pc_en),
    .iord        (iord),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'b000000; funct = 6'b000000; zero = 1'b0;
    #1;
    total++;
    if (obs !== V_RST) begin bad++; $display("FAIL reset_hold got=%b want=%b", obs, V_RST); end
    tick();
    total++;
    if (obs !== V_RST) begin bad++; $display("FAIL reset_after_edge got=%b want=%b", obs, V_RST); end
    rst = 1'b0;
    #1;
    total++;
    if (obs !== V_FETCH) begin bad++; $display("FAIL reset_release_fetch got=%b want=%b", obs, V_FETCH); end
  endtask

  // lw; opcode is changed to sw once MEMRD is reached, which must not divert the sequence
  task automatic test_lw();
    logic [16:0] exp [6];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
    opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) opcode = 6'b101011;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL lw_cycle%0d got=%b want=%b", i + 1, obs, exp[i]); end
      if (i < 5) tick();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [6];
    logic [2:0] ac [6];
    logic [16:0] exp [5];
    fn = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111111};
    ac = '{3'b111, 3'b010, 3'b110, 3'b000, 3'b001, 3'b010};
    opcode = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      funct = fn[k];
      exp = '{V_FETCH, V_DECODE, V_EXEC_B | {12'd0, ac[k], 2'b00}, V_ALUWB, V_FETCH};
      for (int i = 0; i < 5; i++) begin
        total++;
        if (obs !== exp[i]) begin
          bad++; $display("FAIL rtype_f%b_cycle%0d got=%b want=%b", fn[k], i + 1, obs, exp[i]);
        end
        if (i < 4) tick();
      end
    end
  endtask

  task automatic test_beq();
    opcode = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      total++;
      if (obs !== V_FETCH) begin bad++; $display("FAIL beq_z%0d_fetch got=%b want=%b", z, obs, V_FETCH); end
      tick();
      total++;
      if (obs !== V_DECODE) begin bad++; $display("FAIL beq_z%0d_decode got=%b want=%b", z, obs, V_DECODE); end
      tick();
      total++;
      if (obs !== (z == 1 ? V_BR_Z1 : V_BR_Z0)) begin
        bad++; $display("FAIL beq_z%0d_branch got=%b want=%b", z, obs, (z == 1 ? V_BR_Z1 : V_BR_Z0));
      end
      // zero flips within the same cycle; pc_en must track it
      zero = ~zero;
      #1;
      total++;
      if (pc_en !== ~z[0]) begin bad++; $display("FAIL beq_z%0d_pc_en_comb got=%b want=%b", z, pc_en, ~z[0]); end
      tick();
      total++;
      if (obs !== V_FETCH) begin bad++; $display("FAIL beq_z%0d_return got=%b want=%b", z, obs, V_FETCH); end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi();
    logic [16:0] exp [5];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_ADDIWB, V_FETCH};
    opcode = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL addi_cycle%0d got=%b want=%b", i + 1, obs, exp[i]); end
      if (i < 4) tick();
    end
  endtask

  task automatic test_illegal();
    logic [16:0] exp [3];
    exp = '{V_FETCH, V_DEC_IL, V_FETCH};
    opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL illegal_cycle%0d got=%b want=%b", i + 1, obs, exp[i]); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp [8];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_FETCH, V_DECODE, V_JUMP, V_FETCH};
    opcode = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) opcode = 6'b000010;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL sw_j_cycle%0d got=%b want=%b", i + 1, obs, exp[i]); end
      if (i < 7) tick();
    end
  endtask

  task automatic test_rst_mid();
    opcode = 6'b100011;
    tick(); tick(); tick();
    total++;
    if (obs !== V_MEMRD) begin bad++; $display("FAIL rstmid_reach_memrd got=%b want=%b", obs, V_MEMRD); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== V_RST) begin bad++; $display("FAIL rstmid_async got=%b want=%b", obs, V_RST); end
    tick();
    total++;
    if (reg_write !== 1'b0 || mem_write !== 1'b0) begin
      bad++; $display("FAIL rstmid_no_write got=%b%b want=00", reg_write, mem_write);
    end
    rst = 1'b0;
    #1;
    total++;
    if (ir_write !== 1'b1 || pc_en !== 1'b1) begin
      bad++; $display("FAIL rstmid_release got=%b%b want=11", ir_write, pc_en);
    end
    tick();
    total++;
    if (obs !== V_DECODE) begin bad++; $display("FAIL rstmid_decode got=%b want=%b", obs, V_DECODE); end
    tick(); tick(); tick(); tick();
    total++;
    if (obs !== V_FETCH) begin bad++; $display("FAIL rstmid_lw_done got=%b want=%b", obs, V_FETCH); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_addi();
    test_illegal();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
